// File: rtl/seg7_pkg.sv
// Shared segment definitions for the 7-segment scan controller: bit positions,
// the hex decode table (active-high, segment a on bit 0) and the per-slot scan state.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-high segment pattern, segment a on bit 0
// through segment g on bit 6.
module seg_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  logic [6:0] pattern;

  assign pattern = SEG_TABLE[nibble];
  assign seg = {pattern[SEG_G], pattern[SEG_F], pattern[SEG_E], pattern[SEG_D],
                pattern[SEG_C], pattern[SEG_B], pattern[SEG_A]};

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment scan controller with a tear-free
// frame buffer. Define SEG7_LZB_EN to enable leading-zero blanking at commit.
module seven_seg_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int REFRESH_HZ   = 1_000,
  parameter int NUM_DIGITS   = 4,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_dp,
  input  logic [NUM_DIGITS-1:0]   wr_blank,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int SLOT_CYCLES = CLK_FREQ / (REFRESH_HZ * NUM_DIGITS);
  localparam int CNT_W       = $clog2(SLOT_CYCLES);
  localparam int DIG_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);
  localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

  generate
    if (SLOT_CYCLES <= GUARD_CYCLES + 1) begin : g_bad_slot
      $error("seven_seg_scan_ctrl: SLOT_CYCLES must exceed GUARD_CYCLES+1");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("seven_seg_scan_ctrl: NUM_DIGITS must be 1..8");
    end
  endgenerate

  logic [CNT_W-1:0]        slot_cnt_reg, slot_cnt_next;
  logic [DIG_W-1:0]        digit_reg, digit_next;
  scan_state_e             state_reg, state_next;
  logic                    frame_end;

  logic                    pending_valid_reg;
  logic [4*NUM_DIGITS-1:0] pending_data_reg, frame_data_reg, src_data;
  logic [NUM_DIGITS-1:0]   pending_dp_reg, frame_dp_reg, src_dp;
  logic [NUM_DIGITS-1:0]   pending_blank_reg, frame_blank_reg, src_blank;
  logic [NUM_DIGITS-1:0]   lzb_mask;
  logic                    commit;

  logic [3:0]              nibble;
  logic [6:0]              seg_pattern;
  logic [NUM_DIGITS-1:0]   an_n_next;
  logic [6:0]              seg_n_next;
  logic                    dp_n_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_reg <= '0;
      digit_reg    <= '0;
      state_reg    <= GUARD;
    end else begin
      slot_cnt_reg <= slot_cnt_next;
      digit_reg    <= digit_next;
      state_reg    <= state_next;
    end
  end

  always_comb begin
    slot_cnt_next = slot_cnt_reg + 1'b1;
    digit_next    = digit_reg;
    frame_end     = 1'b0;
    state_next    = state_reg;
    if (slot_cnt_reg == CNT_LAST) begin
      slot_cnt_next = '0;
      digit_next    = (digit_reg == DIG_LAST) ? '0 : digit_reg + 1'b1;
      frame_end     = (digit_reg == DIG_LAST);
    end
    case (state_reg)
      GUARD:   if (slot_cnt_next >= GUARD_END) state_next = DRIVE;
      DRIVE:   if (slot_cnt_next <  GUARD_END) state_next = GUARD;
      default: state_next = GUARD;
    endcase
  end

`ifdef SEG7_LZB_EN
  logic seen_nonzero;
  // Walk down from the top digit; everything above the first nonzero nibble goes dark.
  always_comb begin
    lzb_mask     = '0;
    seen_nonzero = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (pending_data_reg[4*i +: 4] != 4'h0) seen_nonzero = 1'b1;
      lzb_mask[i] = ~seen_nonzero;
    end
  end
`else
  assign lzb_mask = '0;
`endif

  assign wr_ready = ~pending_valid_reg;
  assign commit   = frame_done & pending_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_valid_reg <= 1'b0;
      pending_data_reg  <= '0;
      pending_dp_reg    <= '0;
      pending_blank_reg <= '0;
      frame_data_reg    <= '0;
      frame_dp_reg      <= '0;
      frame_blank_reg   <= '1;
    end else begin
      if (commit) begin
        frame_data_reg    <= pending_data_reg;
        frame_dp_reg      <= pending_dp_reg;
        frame_blank_reg   <= pending_blank_reg | lzb_mask;
        pending_valid_reg <= 1'b0;
      end
      if (wr_valid && wr_ready) begin
        pending_valid_reg <= 1'b1;
        pending_data_reg  <= wr_data;
        pending_dp_reg    <= wr_dp;
        pending_blank_reg <= wr_blank;
      end
    end
  end

  // On the commit cycle the incoming frame is already the one being scanned.
  assign src_data  = commit ? pending_data_reg : frame_data_reg;
  assign src_dp    = commit ? pending_dp_reg : frame_dp_reg;
  assign src_blank = commit ? (pending_blank_reg | lzb_mask) : frame_blank_reg;
  assign nibble    = src_data[{digit_reg, 2'b00} +: 4];

  seg_hex_decoder u_decoder (
    .nibble (nibble),
    .seg    (seg_pattern)
  );

  always_comb begin
    an_n_next  = '1;
    seg_n_next = '1;
    dp_n_next  = 1'b1;
    if (state_reg == DRIVE && !src_blank[digit_reg]) begin
      an_n_next[digit_reg] = 1'b0;
      seg_n_next           = ~seg_pattern;
      dp_n_next            = ~src_dp[digit_reg];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n       <= '1;
      seg_n      <= '1;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an_n       <= an_n_next;
      seg_n      <= seg_n_next;
      dp_n       <= dp_n_next;
      frame_done <= frame_end;
    end
  end

endmodule
